// File: rtl/erode_pkg.sv
// Shared constants and types for the erode stage. Optional dilation select
// is compiled in with ERODE_DILATE_SEL_EN (see erode.sv).
package erode_pkg;

    localparam int DEF_IMG_WIDTH  = 1024;
    localparam int DEF_IMG_HEIGHT = 768;
    localparam int DEF_CNT_W      = 11;

    typedef logic [11:0] pixel_t;

    localparam pixel_t DEF_PIX_ON  = 12'hFFF;
    localparam pixel_t DEF_PIX_OFF = 12'h000;

endpackage

// File: rtl/erode_line_buffer.sv
// One-line, 1-bit-wide buffer. Combinational read of the addressed bit and
// synchronous write, so a read in the same cycle as a write returns the
// previous contents. Addresses at or beyond DEPTH read 0 and never write.
module erode_line_buffer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wdata,
    output logic              rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             mem [DEPTH];
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign in_range = (addr < ADDR_W'(DEPTH));
    assign idx      = addr[IDX_W-1:0];
    assign rdata    = in_range ? mem[idx] : 1'b0;

    // Store the incoming bit; contents survive reset.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/erode.sv
// Streaming 3x3 binary erosion of the sobel edge map, one pixel per clock.
// Optional macro ERODE_DILATE_SEL_EN adds a 'dilate' input selecting 3x3
// dilation (any bit set) instead of erosion (all bits set).
module erode
    import erode_pkg::*;
#(
    parameter int     IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int     IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int     CNT_W      = DEF_CNT_W,
    parameter pixel_t PIX_ON     = DEF_PIX_ON,
    parameter pixel_t PIX_OFF    = DEF_PIX_OFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    input  logic             sobel_value,
`ifdef ERODE_DILATE_SEL_EN
    input  logic             dilate,
`endif
    output pixel_t           erode_value
);

    logic       active;
    logic       border_ok;
    logic       lb_we;
    logic       lb0_q;
    logic       lb1_q;
    logic [2:0] new_col;
    logic [2:0] col_a;
    logic [2:0] col_b;
    logic [8:0] window;
    logic       hit;

    assign active    = (hcount < CNT_W'(IMG_WIDTH)) && (vcount < CNT_W'(IMG_HEIGHT));
    assign border_ok = (hcount >= CNT_W'(2)) && (vcount >= CNT_W'(2));
    assign lb_we     = active && rst;

    // lb0 holds row v-1, lb1 holds row v-2; lb1 is fed from lb0's old bit.
    erode_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (CNT_W)
    ) lb0 (
        .clk   (clk),
        .we    (lb_we),
        .addr  (hcount),
        .wdata (sobel_value),
        .rdata (lb0_q)
    );

    erode_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (CNT_W)
    ) lb1 (
        .clk   (clk),
        .we    (lb_we),
        .addr  (hcount),
        .wdata (lb0_q),
        .rdata (lb1_q)
    );

    // Column entering the window this cycle, top (row v-2) to bottom (row v).
    assign new_col = {lb1_q, lb0_q, sobel_value};

    // Window as it stands after the shift: two stored columns plus the
    // incoming one. The oldest stored column falls out, so only two are kept.
    assign window = {col_a, col_b, new_col};

    // Neighbourhood test: erosion needs every bit, dilation any bit.
    always_comb begin
        hit = &window;
`ifdef ERODE_DILATE_SEL_EN
        if (dilate) begin
            hit = |window;
        end
`endif
    end

    // Window shift and registered output; blanking holds the window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_a       <= '0;
            col_b       <= '0;
            erode_value <= PIX_OFF;
        end else if (active) begin
            col_a       <= col_b;
            col_b       <= new_col;
            erode_value <= (hit && border_ok) ? PIX_ON : PIX_OFF;
        end else begin
            erode_value <= PIX_OFF;
        end
    end

endmodule

// File: tb/tb_erode.sv
// Directed self-checking bench for erode on an 8x6 image.
module tb_erode;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        sobel_value;
    logic [11:0] erode_value;
`ifdef ERODE_DILATE_SEL_EN
    logic        dilate;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    erode #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .CNT_W      (11),
        .PIX_ON     (12'hFFF),
        .PIX_OFF    (12'h000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .sobel_value (sobel_value),
`ifdef ERODE_DILATE_SEL_EN
        .dilate      (dilate),
`endif
        .erode_value (erode_value)
    );

    // Present one sample and wait until just after the edge that consumes it.
    task automatic drive(input int h, input int v, input logic s, input logic r);
        @(negedge clk);
        rst         = r;
        hcount      = 11'(h);
        vcount      = 11'(v);
        sobel_value = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            drive(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 1'($urandom), 1'b0);
            checks++;
            if (erode_value !== 12'h000) begin
                failures++;
                $display("FAIL reset cycle=%0d got=%h exp=%h", i, erode_value, 12'h000);
            end
        end
    endtask

    task automatic test_checkerboard;
        for (int v = 0; v < 11; v++) begin
            for (int h = 0; h < 21; h++) begin
                drive(h, v, 1'((h ^ v) & 1), 1'b1);
                checks++;
                if (erode_value !== 12'h000) begin
                    failures++;
                    $display("FAIL checkerboard h=%0d v=%0d got=%h exp=%h", h, v, erode_value, 12'h000);
                end
            end
        end
    endtask

    task automatic test_all_ones;
        logic [11:0] exp;
        for (int v = 0; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                drive(h, v, 1'b1, 1'b1);
                exp = (h >= 2 && v >= 2) ? 12'hFFF : 12'h000;
                checks++;
                if (erode_value !== exp) begin
                    failures++;
                    $display("FAIL all_ones h=%0d v=%0d got=%h exp=%h", h, v, erode_value, exp);
                end
            end
        end
    endtask

    task automatic test_single_hole;
        logic [11:0] exp;
        logic        s;
        logic        in_hole;
        for (int v = 0; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                s = !(h == 4 && v == 3);
                drive(h, v, s, 1'b1);
                in_hole = (h >= 4 && h <= 6 && v >= 3 && v <= 5);
                exp = (h >= 2 && v >= 2 && !in_hole) ? 12'hFFF : 12'h000;
                checks++;
                if (erode_value !== exp) begin
                    failures++;
                    $display("FAIL hole h=%0d v=%0d got=%h exp=%h", h, v, erode_value, exp);
                end
            end
        end
    endtask

    task automatic test_blanking;
        logic [11:0] exp;
        for (int v = 0; v < H; v++) begin
            if (v == 3) begin
                // Vertical-blank samples of zeros must not touch the buffers.
                for (int h = 0; h < W; h++) begin
                    drive(h, H, 1'b0, 1'b1);
                    checks++;
                    if (erode_value !== 12'h000) begin
                        failures++;
                        $display("FAIL vblank h=%0d got=%h exp=%h", h, erode_value, 12'h000);
                    end
                end
            end
            for (int h = 0; h < W; h++) begin
                if (h == 5) begin
                    // A mid-line blank sample of zero must not shift the window.
                    drive(W + 1, v, 1'b0, 1'b1);
                    checks++;
                    if (erode_value !== 12'h000) begin
                        failures++;
                        $display("FAIL hblank_mid v=%0d got=%h exp=%h", v, erode_value, 12'h000);
                    end
                end
                drive(h, v, 1'b1, 1'b1);
                exp = (h >= 2 && v >= 2) ? 12'hFFF : 12'h000;
                checks++;
                if (erode_value !== exp) begin
                    failures++;
                    $display("FAIL blank_active h=%0d v=%0d got=%h exp=%h", h, v, erode_value, exp);
                end
            end
            for (int h = W; h < W + 4; h++) begin
                drive(h, v, 1'b1, 1'b1);
                checks++;
                if (erode_value !== 12'h000) begin
                    failures++;
                    $display("FAIL hblank h=%0d v=%0d got=%h exp=%h", h, v, erode_value, 12'h000);
                end
            end
        end
    endtask

    task automatic test_reset_midline;
        logic [11:0] exp;
        logic        r;
        for (int v = 0; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                r = !(v == 3 && h == 4);
                drive(h, v, 1'b1, r);
                if (v == 3 && h >= 4 && h <= 6) begin
                    exp = 12'h000;
                end else begin
                    exp = (h >= 2 && v >= 2) ? 12'hFFF : 12'h000;
                end
                checks++;
                if (erode_value !== exp) begin
                    failures++;
                    $display("FAIL reset_midline h=%0d v=%0d got=%h exp=%h", h, v, erode_value, exp);
                end
            end
        end
    endtask

`ifdef ERODE_DILATE_SEL_EN
    task automatic test_dilate;
        logic [11:0] exp;
        dilate = 1'b1;
        for (int v = 0; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                drive(h, v, 1'(h == 4 && v == 3), 1'b1);
                exp = (h >= 4 && h <= 6 && v >= 3 && v <= 5) ? 12'hFFF : 12'h000;
                checks++;
                if (erode_value !== exp) begin
                    failures++;
                    $display("FAIL dilate h=%0d v=%0d got=%h exp=%h", h, v, erode_value, exp);
                end
            end
        end
        dilate = 1'b0;
    endtask
`endif

    initial begin
        rst         = 1'b0;
        hcount      = '0;
        vcount      = '0;
        sobel_value = 1'b0;
`ifdef ERODE_DILATE_SEL_EN
        dilate      = 1'b0;
`endif
        test_reset();
        test_checkerboard();
        test_all_ones();
        test_single_hole();
        test_blanking();
        test_reset_midline();
`ifdef ERODE_DILATE_SEL_EN
        test_dilate();
`endif
        test_all_ones();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
